// File: rtl/image_uart_transmitter.sv
// Streams IMAGE_BYTES bytes from the image RAM read port out of an 8N1 UART line.
// state  | meaning
// IDLE   | line high, waiting for start_transmission_i
// FETCH  | address stable, waiting RAM_LATENCY+1 cycles, then capture the byte
// START  | start bit (low) for CLKS_PER_BIT cycles
// DATA   | eight data bits, LSB first
// STOP   | stop bit (high); byte/image completion pulses on its last cycle
module image_uart_transmitter #(
  parameter int          CLKS_PER_BIT = 5208,
  parameter int          IMAGE_BYTES  = 65536,
  parameter logic [15:0] START_ADDR   = 16'h0000,
  parameter int          RAM_LATENCY  = 1
) (
  input  logic        main_clock_i,
  input  logic        reset_n_i,
  input  logic        start_transmission_i,
  output logic [15:0] ex_address_o,
  input  logic [7:0]  ex_dataout_i,
  output logic        uart_tx_o,
  output logic        tx_busy_o,
  output logic        transmitted_8_bits_o,
  output logic        transmission_done_o
);

  localparam int BAUD_W  = $clog2(CLKS_PER_BIT);
  localparam int FETCH_W = (RAM_LATENCY > 0) ? $clog2(RAM_LATENCY + 1) : 1;

  localparam logic [BAUD_W-1:0]  BAUD_RELOAD = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0]  BAUD_ONE    = BAUD_W'(1);
  localparam logic [FETCH_W-1:0] FETCH_LAST  = FETCH_W'(RAM_LATENCY);
  localparam logic [16:0]        LAST_BYTE   = 17'(IMAGE_BYTES - 1);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FETCH = 3'd1;
  localparam logic [2:0] ST_START = 3'd2;
  localparam logic [2:0] ST_DATA  = 3'd3;
  localparam logic [2:0] ST_STOP  = 3'd4;

  logic [2:0]         state_q, state_d;
  logic [15:0]        addr_q, addr_d;
  logic [16:0]        count_q, count_d;
  logic [FETCH_W-1:0] fetch_q, fetch_d;
  logic [BAUD_W-1:0]  baud_q, baud_d;
  logic [2:0]         bit_q, bit_d;
  logic [7:0]         shift_q, shift_d;

  logic uart_tx_q, uart_tx_d;
  logic busy_q, busy_d;
  logic byte_pulse_q, byte_pulse_d;
  logic done_pulse_q, done_pulse_d;

  logic baud_zero;
  logic last_byte;

  assign baud_zero = (baud_q == '0);
  assign last_byte = (count_q == LAST_BYTE);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    count_d = count_q;
    fetch_d = fetch_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    case (state_q)
      ST_IDLE: begin
        if (start_transmission_i) begin
          state_d = ST_FETCH;
          addr_d  = START_ADDR;
          count_d = '0;
          fetch_d = '0;
        end
      end
      ST_FETCH: begin
        if (fetch_q == FETCH_LAST) begin
          shift_d = ex_dataout_i;
          baud_d  = BAUD_RELOAD;
          state_d = ST_START;
        end else begin
          fetch_d = fetch_q + FETCH_W'(1);
        end
      end
      ST_START: begin
        if (baud_zero) begin
          baud_d  = BAUD_RELOAD;
          bit_d   = 3'd0;
          state_d = ST_DATA;
        end else begin
          baud_d = baud_q - BAUD_W'(1);
        end
      end
      ST_DATA: begin
        if (baud_zero) begin
          baud_d  = BAUD_RELOAD;
          shift_d = shift_q >> 1;
          if (bit_q == 3'd7) begin
            state_d = ST_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_q - BAUD_W'(1);
        end
      end
      ST_STOP: begin
        if (baud_zero) begin
          if (last_byte) begin
            // address is left on the final byte; the image never wraps
            state_d = ST_IDLE;
          end else begin
            addr_d  = addr_q + 16'd1;
            count_d = count_q + 17'd1;
            fetch_d = '0;
            state_d = ST_FETCH;
          end
        end else begin
          baud_d = baud_q - BAUD_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Line follows the current state one cycle later, so the start bit appears
  // one cycle after FETCH ends and the stop bit runs into the next FETCH gap.
  always_comb begin
    uart_tx_d = 1'b1;
    case (state_q)
      ST_START: uart_tx_d = 1'b0;
      ST_DATA:  uart_tx_d = shift_q[0];
      default:  uart_tx_d = 1'b1;
    endcase
  end

  // Pulses are raised one cycle early so they land on the last STOP cycle.
  assign byte_pulse_d = (state_q == ST_STOP) && (baud_q == BAUD_ONE);
  assign done_pulse_d = byte_pulse_d && last_byte;
  assign busy_d       = (state_d != ST_IDLE);

  always_ff @(posedge main_clock_i) begin
    if (!reset_n_i) begin
      state_q      <= ST_IDLE;
      addr_q       <= START_ADDR;
      count_q      <= '0;
      fetch_q      <= '0;
      baud_q       <= '0;
      bit_q        <= '0;
      shift_q      <= '0;
      uart_tx_q    <= 1'b1;
      busy_q       <= 1'b0;
      byte_pulse_q <= 1'b0;
      done_pulse_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      count_q      <= count_d;
      fetch_q      <= fetch_d;
      baud_q       <= baud_d;
      bit_q        <= bit_d;
      shift_q      <= shift_d;
      uart_tx_q    <= uart_tx_d;
      busy_q       <= busy_d;
      byte_pulse_q <= byte_pulse_d;
      done_pulse_q <= done_pulse_d;
    end
  end

  assign ex_address_o         = addr_q;
  assign uart_tx_o            = uart_tx_q;
  assign tx_busy_o            = busy_q;
  assign transmitted_8_bits_o = byte_pulse_q;
  assign transmission_done_o  = done_pulse_q;

endmodule

// File: tb/tb_image_uart_transmitter.sv
// Bench for image_uart_transmitter: a 3-byte image DUT and a 1-byte boundary DUT at 16'hFFFF,
// both compared every cycle against a frame-timing model, plus directed literal checks.
module tb_image_uart_transmitter;

  localparam int CPB    = 4;
  localparam int PERIOD = 2 + 10 * CPB;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic start_b = 1'b0;

  logic [15:0] addr0, addr1;
  logic [7:0]  ram0, ram1;
  logic        tx0, busy0, pulse0, done0;
  logic        tx1, busy1, pulse1, done1;

  always #5 clk = ~clk;

  image_uart_transmitter #(.CLKS_PER_BIT(CPB), .IMAGE_BYTES(3), .START_ADDR(16'h0010), .RAM_LATENCY(1)) dut (
    .main_clock_i(clk), .reset_n_i(rst_n), .start_transmission_i(start),
    .ex_address_o(addr0), .ex_dataout_i(ram0), .uart_tx_o(tx0), .tx_busy_o(busy0),
    .transmitted_8_bits_o(pulse0), .transmission_done_o(done0));

  image_uart_transmitter #(.CLKS_PER_BIT(CPB), .IMAGE_BYTES(1), .START_ADDR(16'hFFFF), .RAM_LATENCY(1)) dut_b (
    .main_clock_i(clk), .reset_n_i(rst_n), .start_transmission_i(start_b),
    .ex_address_o(addr1), .ex_dataout_i(ram1), .uart_tx_o(tx1), .tx_busy_o(busy1),
    .transmitted_8_bits_o(pulse1), .transmission_done_o(done1));

  always @(posedge clk) begin
    ram0 <= addr0[7:0] ^ 8'hA5;
    ram1 <= 8'h00;
  end

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      if (fails < 40) $display("FAIL %s: actual %0h, required %0h", nm, act, exp);
    end
  endtask

  // ---------------- model: frame timing from accept edge ----------------
  int cyc = 0;
  bit mact[2];
  int t0[2];

  function automatic int nb_of(input int d);
    return (d == 0) ? 3 : 1;
  endfunction

  function automatic logic [15:0] sa_of(input int d);
    return (d == 0) ? 16'h0010 : 16'hFFFF;
  endfunction

  // sel: 0 line, 1 busy, 2 byte pulse, 3 done pulse, 4 address
  function automatic logic [15:0] exp_val(input int sel, input bit a, input int k, input int d);
    int nb, b, p, bi;
    logic [15:0] sa, ad;
    logic [7:0] dat;
    nb = nb_of(d);
    sa = sa_of(d);
    if (!a) return (sel == 0) ? 16'd1 : ((sel == 4) ? sa : 16'd0);
    case (sel)
      0: begin
        if (k < 3 || k >= 3 + PERIOD * nb) return 16'd1;
        b = (k - 3) / PERIOD;
        p = (k - 3) % PERIOD;
        if (p < CPB) return 16'd0;
        if (p >= 9 * CPB) return 16'd1;
        ad = sa + 16'(b);
        dat = (d == 0) ? (ad[7:0] ^ 8'hA5) : 8'h00;
        bi = (p - CPB) / CPB;
        return {15'd0, dat[bi]};
      end
      1: return {15'd0, k < PERIOD * nb};
      2: return {15'd0, (k < PERIOD * nb) && (k % PERIOD == PERIOD - 1)};
      3: return {15'd0, k == PERIOD * nb - 1};
      default: begin
        b = k / PERIOD;
        if (b > nb - 1) b = nb - 1;
        return sa + 16'(b);
      end
    endcase
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) mact[d] <= 1'b0;
      else if (((d == 0) ? start : start_b) &&
               (!mact[d] || (cyc + 1 - t0[d]) >= PERIOD * nb_of(d) + 1)) begin
        mact[d] <= 1'b1;
        t0[d]   <= cyc + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int d = 0; d < 2; d++) begin
        int k;
        k = cyc - t0[d];
        chk($sformatf("d%0d_uart_tx cyc%0d", d, cyc), {31'd0, (d == 0) ? tx0 : tx1}, {16'd0, exp_val(0, mact[d], k, d)});
        chk($sformatf("d%0d_tx_busy cyc%0d", d, cyc), {31'd0, (d == 0) ? busy0 : busy1}, {16'd0, exp_val(1, mact[d], k, d)});
        chk($sformatf("d%0d_byte_pulse cyc%0d", d, cyc), {31'd0, (d == 0) ? pulse0 : pulse1}, {16'd0, exp_val(2, mact[d], k, d)});
        chk($sformatf("d%0d_done_pulse cyc%0d", d, cyc), {31'd0, (d == 0) ? done0 : done1}, {16'd0, exp_val(3, mact[d], k, d)});
        chk($sformatf("d%0d_ex_address cyc%0d", d, cyc), {16'd0, (d == 0) ? addr0 : addr1}, {16'd0, exp_val(4, mact[d], k, d)});
      end
    end
  end

  // ---------------- independent UART decoders and event recorders ----------------
  logic [7:0] rx0[$];
  logic [7:0] rx1[$];
  int pq0[$];
  int dq0[$];
  int done1_cnt = 0;
  int busy_cnt0 = 0;
  bit dact[2];
  int dn[2];
  logic [7:0] dsh[2];

  always @(negedge clk) begin
    if (chk_en) begin
      if (pulse0) pq0.push_back(cyc);
      if (done0) dq0.push_back(cyc);
      if (done1) done1_cnt++;
      if (busy0) busy_cnt0++;
    end
    for (int d = 0; d < 2; d++) begin
      logic ln;
      ln = (d == 0) ? tx0 : tx1;
      if (!rst_n || !chk_en) dact[d] = 1'b0;
      else if (!dact[d]) begin
        if (ln === 1'b0) begin
          dact[d] = 1'b1;
          dn[d] = 0;
        end
      end else begin
        dn[d]++;
        if (dn[d] == 2) chk($sformatf("d%0d_start_bit", d), {31'd0, ln}, 32'd0);
        if (dn[d] >= 5 && dn[d] <= 33 && ((dn[d] - 5) % 4) == 0) dsh[d] = {ln, dsh[d][7:1]};
        if (dn[d] == 37) begin
          chk($sformatf("d%0d_stop_bit", d), {31'd0, ln}, 32'd1);
          if (d == 0) rx0.push_back(dsh[d]);
          else rx1.push_back(dsh[d]);
          dact[d] = 1'b0;
        end
      end
    end
  end

  task automatic clear_rec();
    rx0.delete(); rx1.delete(); pq0.delete(); dq0.delete();
    done1_cnt = 0; busy_cnt0 = 0;
  endtask

  task automatic wait_idle(input int d, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (((d == 0) ? busy0 : busy1) == 1'b0) break;
    end
    chk($sformatf("d%0d_busy_timeout", d), {31'd0, (d == 0) ? busy0 : busy1}, 32'd0);
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic check_image(input string nm);
    logic [7:0] expb[3];
    expb[0] = 8'hB5; expb[1] = 8'hB4; expb[2] = 8'hB7;
    chk({nm, "_bytes"}, rx0.size(), 32'd3);
    for (int i = 0; i < 3 && i < rx0.size(); i++) chk($sformatf("%s_byte%0d", nm, i), {24'd0, rx0[i]}, {24'd0, expb[i]});
  endtask

  initial begin
    int n;
    // reset idle
    repeat (5) @(negedge clk);
    chk_en = 1'b1;
    rst_n = 1'b1;
    clear_rec();
    repeat (50) @(negedge clk);
    chk("idle_uart", {31'd0, tx0}, 32'd1);
    chk("idle_busy", {31'd0, busy0}, 32'd0);
    chk("idle_addr", {16'd0, addr0}, 32'h0010);
    chk("idle_pulses", pq0.size() + dq0.size(), 32'd0);

    // single frame
    clear_rec();
    pulse_start();
    n = 0;
    while (tx0 !== 1'b0 && n < 20) begin @(negedge clk); n++; end
    chk("start_latency", n, 32'd3);
    wait_idle(0, 300);
    repeat (5) @(negedge clk);
    check_image("single");
    chk("busy_cycles", busy_cnt0, 32'd126);
    chk("pulse_count", pq0.size(), 32'd3);
    if (pq0.size() == 3) begin
      chk("pulse_gap1", pq0[1] - pq0[0], 32'd42);
      chk("pulse_gap2", pq0[2] - pq0[1], 32'd42);
      chk("done_with_last", (dq0.size() == 1) ? dq0[0] : -1, pq0[2]);
    end

    // retrigger while busy
    clear_rec();
    pulse_start();
    repeat (19) @(negedge clk);
    start = 1'b1; @(negedge clk); start = 1'b0;
    repeat (39) @(negedge clk);
    start = 1'b1; @(negedge clk); start = 1'b0;
    wait_idle(0, 300);
    repeat (5) @(negedge clk);
    check_image("retrig");
    chk("retrig_pulses", pq0.size(), 32'd3);
    chk("retrig_addr", {16'd0, addr0}, 32'h0012);

    // held start
    clear_rec();
    @(negedge clk); start = 1'b1;
    n = 0;
    while (done0 !== 1'b1 && n < 300) begin @(negedge clk); n++; end
    chk("held_done_seen", {31'd0, done0}, 32'd1);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (busy0 === 1'b1) break;
      n++;
    end
    chk("held_idle_cycles", n, 32'd1);
    chk("held_restart_addr", {16'd0, addr0}, 32'h0010);
    start = 1'b0;
    wait_idle(0, 300);
    repeat (5) @(negedge clk);
    chk("held_bytes", rx0.size(), 32'd6);
    if (rx0.size() == 6) chk("held_byte3", {24'd0, rx0[3]}, 32'hB5);

    // reset mid-byte (byte 2, data bit 3)
    clear_rec();
    pulse_start();
    repeat (61) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_uart", {31'd0, tx0}, 32'd1);
    chk("rst_busy", {31'd0, busy0}, 32'd0);
    chk("rst_addr", {16'd0, addr0}, 32'h0010);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    clear_rec();
    pulse_start();
    wait_idle(0, 300);
    repeat (5) @(negedge clk);
    check_image("after_rst");

    // boundary: one byte at 16'hFFFF
    clear_rec();
    @(negedge clk); start_b = 1'b1;
    @(negedge clk); start_b = 1'b0;
    wait_idle(1, 100);
    repeat (5) @(negedge clk);
    chk("bnd_bytes", rx1.size(), 32'd1);
    if (rx1.size() == 1) chk("bnd_byte", {24'd0, rx1[0]}, 32'h00);
    chk("bnd_done_count", done1_cnt, 32'd1);
    repeat (10) @(negedge clk);
    chk("bnd_addr", {16'd0, addr1}, 32'hFFFF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/image_uart_transmitter.md
# image_uart_transmitter

Streams the processed image out of `IMAGE_RAM` over a UART serial line once the CPU finishes. It reads bytes through the RAM's external read port (`ex_address` / `ex_dataout`), serialises each one as 8N1, and reports per-byte and end-of-image events. It is the read/transmit end of the path whose write end is the CPU's `CPU_ADDRESS` / `CPU_DATA` port. It sits beside `PROCESSOR` in the top level, triggered by `PROCESS_DONE`.

## Interface
- `CLKS_PER_BIT`, 5208, MAIN_CLOCK cycles per UART bit (50 MHz / 9600 baud); must be ≥ 2.
- `IMAGE_BYTES`, 65536, number of bytes sent per transmission; must be ≥ 1.
- `START_ADDR`, 0, first RAM address sent; constraint: START_ADDR + IMAGE_BYTES − 1 ≤ 65535.
- `RAM_LATENCY`, 1, clock edges from an EX_ADDRESS change until EX_DATAOUT is valid at the RAM output.

- `MAIN_CLOCK`  in  1  single clock for the whole block; same clock as the IMAGE_RAM read port.
- `RESET_N`  in  1  synchronous, active-low reset.
- `START_TRANSMISSION`  in  1  level/pulse; sampled only in IDLE.
- `EX_ADDRESS`  out  16  registered RAM read address.
- `EX_DATAOUT`  in  8  RAM read data.
- `UART_TX`  out  1  registered serial line; idle high.
- `TX_BUSY`  out  1  high while a transmission is in progress.
- `TRANSMITTED_8_BITS`  out  1  one-cycle pulse per byte completed.
- `TRANSMISSION_DONE`  out  1  one-cycle pulse when the final byte completes.

## Operation
- States: IDLE, FETCH, START, DATA, STOP.
- **IDLE**
  - UART_TX = 1, TX_BUSY = 0.
  - If START_TRANSMISSION = 1 at an edge: EX_ADDRESS ← START_ADDR, byte count ← 0, go to FETCH, TX_BUSY ← 1.
- **FETCH**
  - Lasts RAM_LATENCY+1 cycles. EX_ADDRESS is held stable and UART_TX stays 1.
  - On the final FETCH edge, EX_DATAOUT is captured into an 8-bit shift register. Go to START.
- **START**
  - UART_TX = 0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
- **DATA**
  - Sends shift-register bits LSB first, each for CLKS_PER_BIT cycles.
  - After bit 7, go to STOP.
- **STOP**
  - UART_TX = 1 for CLKS_PER_BIT cycles.
  - On the last STOP cycle, TRANSMITTED_8_BITS = 1.
  - If byte count = IMAGE_BYTES−1: TRANSMISSION_DONE = 1 on that same cycle, then IDLE. EX_ADDRESS holds its last value.
  - Otherwise: EX_ADDRESS ← EX_ADDRESS+1, byte count +1, go to FETCH.
- The baud counter is internal, wide enough for CLKS_PER_BIT−1, and reloads at every bit boundary. There is no fractional baud.
- EX_ADDRESS never wraps past START_ADDR+IMAGE_BYTES−1. The byte counter is 17 bits, so IMAGE_BYTES = 65536 is legal.
- START_TRANSMISSION outside IDLE is ignored and not queued. If it is held high, a new image starts on the cycle after TRANSMISSION_DONE's IDLE cycle.
- EX_DATAOUT is sampled only on the capture edge. Changes at any other time have no effect on the frame.

## Timing
- Reset values (RESET_N = 0 at an edge):
  - State = IDLE, UART_TX = 1, TX_BUSY = 0, TRANSMITTED_8_BITS = 0, TRANSMISSION_DONE = 0.
  - EX_ADDRESS = START_ADDR; all counters = 0.
- Reset mid-frame: the line returns high on the next edge. No partial stop bit and no pulses are emitted.
- Start latency: UART_TX falls (RAM_LATENCY+1)+1 cycles after the edge that accepts START_TRANSMISSION.
  - Accept edge → FETCH, RAM_LATENCY+1 cycles → START.
- Byte period: (RAM_LATENCY+1) + 10·CLKS_PER_BIT cycles per byte. UART_TX stays high through the inter-byte FETCH gap.
- Total busy time: IMAGE_BYTES · byte period cycles. TX_BUSY falls on the edge after TRANSMISSION_DONE.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
Unless stated otherwise, the bench uses CLKS_PER_BIT=4, IMAGE_BYTES=3, START_ADDR=16'h0010, RAM_LATENCY=1, with a RAM model returning addr[7:0]^8'hA5 after 1 edge.

- **Reset idle:** hold RESET_N=0 for 5 cycles, then release with no start.
  - UART_TX=1, TX_BUSY=0 and EX_ADDRESS=16'h0010 for 50 cycles; no pulses.
- **Single frame:** pulse START_TRANSMISSION for 1 cycle.
  - Line falls 3 cycles after the accept edge.
  - Decodes bytes 8'hB5, 8'hB4, 8'hB7 (LSB first, 4 cycles/bit).
  - TRANSMITTED_8_BITS pulses at 42-cycle spacing; TRANSMISSION_DONE coincides with the 3rd pulse.
  - TX_BUSY is high for exactly 126 cycles.
- **Retrigger while busy:** pulse START at cycle 20 and cycle 60 of a transmission.
  - Both pulses are ignored: exactly 3 bytes are sent and EX_ADDRESS ends at 16'h0012.
- **Held start:** hold START_TRANSMISSION=1 continuously.
  - After DONE there is exactly 1 IDLE cycle, then a second image restarts at 16'h0010.
- **Reset mid-byte:** assert RESET_N=0 during DATA bit 3 of byte 2.
  - The next edge gives UART_TX=1, TX_BUSY=0, EX_ADDRESS=16'h0010.
  - A later START resends all 3 bytes from the beginning.
- **Boundary:** IMAGE_BYTES=1, START_ADDR=16'hFFFF, RAM returning 8'h00.
  - One frame is sent: start bit 0, eight 0 data bits, stop bit 1.
  - DONE pulses once, EX_ADDRESS stays 16'hFFFF, no wrap.
